// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch-operand stall, IF/ID flush and stall-cycle counter
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              branch_taken,
    output logic              hold,
    output logic              Repeat,
    output logic              nop,
    output logic              flush,
    output logic              stall_busy,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam int CW = $clog2(LOAD_LAT + 2);
    typedef enum logic {IDLE, STALL} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, n;
    logic match, stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end
    // qualifiers are tested first so X on unqualified register fields cannot leak out
    always_comb begin
        match = ex_rd != '0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        n = (ex_mem_read && match) ? (id_branch ? CW'(LOAD_LAT + 1) : CW'(LOAD_LAT)) :
            (id_branch && ex_reg_write && match) ? CW'(1) : CW'(0);
        state_nxt = state;
        cnt_nxt = cnt;
        if (state == IDLE) begin
            state_nxt = n > CW'(1) ? STALL : IDLE;
            cnt_nxt = n > CW'(1) ? n - CW'(1) : cnt;
        end else begin
            state_nxt = cnt == CW'(1) ? IDLE : STALL;
            cnt_nxt = cnt - CW'(1);
        end
    end
    always_comb begin
        stall = !rst && (state == STALL || n != '0);
        hold = stall;
        Repeat = stall;
        nop = stall;
        stall_busy = !rst && state == STALL;
        flush = branch_taken && !stall && !rst;
    end
endmodule
